// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  // Fetch sequencer states; also exported on the debug port.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DISCARD  = 2'd3
  } fetch_state_t;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched words; clear beats push and pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_clear,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == DEPTH_C);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | i_pop);
  assign w_do_pop  = i_pop & ~o_empty;

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
    end
  end

  // Storage write; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && !i_clear && w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, single-outstanding memory reads,
// instruction buffer and redirect (flush) handling.
//
// Handshakes: a memory read is transferred on a cycle with imem_req_o and
// imem_gnt_i both high, and its single response arrives later as one cycle of
// imem_rvalid_i; a buffered instruction moves to decode on a cycle with
// instr_v_o and instr_ready_i both high. Valid never depends on ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_o,
  output logic [XLEN-1:0]    imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               flush_i,
  input  logic [XLEN-1:0]    flush_pc_i,
  output logic               instr_v_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [XLEN-1:0]    pc_o,
  input  logic               instr_ready_i,
  output fetch_state_t       dbg_state_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t     r_state;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_req_pc;
  logic             r_req;
  logic [XLEN-1:0]  r_addr;

  logic [XLEN-1:0]  w_flush_pc;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic [CW-1:0]    w_count;
  logic [CW-1:0]    w_count_after_push;
  logic             w_has_space;
  fetch_entry_t     w_entry_in;
  fetch_entry_t     w_head;

  assign w_flush_pc         = align_pc(flush_pc_i);
  // Responses are only kept in WAIT_RSP and never in a redirect cycle.
  assign w_push             = (r_state == WAIT_RSP) & imem_rvalid_i & ~flush_i;
  assign w_pop              = ~w_empty & instr_ready_i;
  assign w_count_after_push = w_count + CW'(1) - CW'(w_pop);
  assign w_has_space        = (w_count < DEPTH_C);
  assign w_entry_in         = '{pc: r_req_pc, instr: imem_rdata_i};

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush_i),
    .i_data  (w_entry_in),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  // Fetch sequencer with registered request/address; a redirect overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
      r_req    <= 1'b0;
      r_addr   <= RESET_PC;
    end else if (flush_i) begin
      r_pc <= w_flush_pc;
      case (r_state)
        REQ: begin
          if (imem_gnt_i) begin
            // The read just granted is still owed a response: swallow it.
            r_state <= DISCARD;
            r_req   <= 1'b0;
          end else begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_addr  <= w_flush_pc;
          end
        end
        WAIT_RSP, DISCARD: begin
          if (imem_rvalid_i) begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_addr  <= w_flush_pc;
          end else begin
            r_state <= DISCARD;
            r_req   <= 1'b0;
          end
        end
        default: begin
          r_state <= REQ;
          r_req   <= 1'b1;
          r_addr  <= w_flush_pc;
        end
      endcase
    end else begin
      case (r_state)
        IDLE: begin
          if (w_has_space) begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
        end
        REQ: begin
          if (imem_gnt_i) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + XLEN'(4);
            r_state  <= WAIT_RSP;
            r_req    <= 1'b0;
          end
        end
        WAIT_RSP: begin
          if (imem_rvalid_i) begin
            if (w_count_after_push < DEPTH_C) begin
              r_state <= REQ;
              r_req   <= 1'b1;
              r_addr  <= r_pc;
            end else begin
              r_state <= IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (imem_rvalid_i) begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o  = r_req;
  assign imem_addr_o = r_addr;
  assign instr_v_o   = ~w_empty;
  assign instr_o     = w_empty ? '0 : w_head.instr;
  assign pc_o        = w_empty ? '0 : w_head.pc;
  assign dbg_state_o = r_state;

  // A response is only legal while one is owed.
  a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid_i |-> (r_state == WAIT_RSP || r_state == DISCARD));

  // The single-outstanding scheme must never push into a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && w_full && !w_pop));

endmodule
